quad_encoder_decoder: RTL and testbench
=======================================

# quad_encoder_decoder

Feedback-side companion to the microstep PWM driver. It receives the motor shaft's incremental quadrature encoder (A/B/Z), synchronises and deglitches the three lines, and decodes them 4x into a signed position count and direction. It also measures the step period for speed estimation and flags illegal transitions. Outputs feed the closed-loop step controller that produces the driver's step-enable.

## Interface
Parameters:
- CNT_W, 16, width of the position and index-capture registers (two's complement)
- PER_W, 20, width of the period counter
- FILT_LEN, 3, consecutive equal samples required to accept a new filtered level (2..8)

Ports:
- CLK  in  1  system clock; one clock domain
- RST_N  in  1  reset, asynchronous assert, active-low
- ENC_A, ENC_B, ENC_Z  in  1 each  raw encoder lines, asynchronous to CLK
- CE  in  1  filter sample enable; a single-cycle pulse from the shared prescaler, or tie high
- CLR  in  1  synchronous clear of POS and the period counter
- ERR_CLR  in  1  synchronous clear of ERR
- POS  out  CNT_W  signed position, +1 per forward edge, -1 per reverse edge
- DIR  out  1  direction of the last count (1 = forward)
- CNT_PULSE  out  1  one-cycle strobe for each accepted count
- IDX_POS  out  CNT_W  POS value captured on the Z rising edge
- IDX_VLD  out  1  one-cycle strobe when IDX_POS updates
- PERIOD  out  PER_W  CLK cycles between the last two counts
- PERIOD_VLD  out  1  one-cycle strobe when PERIOD updates
- ERR  out  1  sticky flag for an illegal transition

## Operation
- Each line passes through a 2-flop synchroniser, then a filter. On every CE the filter shifts in one sample. The filtered level changes only when FILT_LEN consecutive samples agree and differ from the current level.
- The decoder holds the previous filtered {A,B}.
  - Forward Gray order is 00→01→11→10→00; each step gives +1.
  - The reverse order gives -1.
  - No change gives no action.
  - Both bits changing is illegal: set ERR, no count, update the held state.
- Priming: after reset the filters hold no level. The first accepted {A,B} loads the decoder state without counting and without raising ERR. Z is primed the same way and never produces an IDX_VLD edge from priming.
- On a count: update POS, set DIR, pulse CNT_PULSE for one cycle.
- On a Z filtered rising edge: IDX_POS takes the POS value after any count in the same cycle, and IDX_VLD pulses.
- Period counter:
  - Increments every cycle and saturates at all-ones.
  - On a count: PERIOD takes the counter value, PERIOD_VLD pulses, and the counter reloads to 1.
  - The first count after reset or CLR gives no PERIOD_VLD.
- Arithmetic: POS wraps modulo 2^CNT_W (0x7FFF+1 = 0x8000, 0x0000-1 = 0xFFFF). No saturation.
- Simultaneous events:
  - CLR together with a count: POS = 0 and DIR updates.
  - ERR_CLR together with a new illegal transition: ERR stays 1.
  - CLR together with a Z edge: IDX_POS = 0.

## Timing
- Reset values: all outputs 0. Filters and decoder are unprimed, and the period counter and its first-count flag are cleared.
- Latency with CE held high: an input edge first sampled by the synchroniser at edge n gives a POS/CNT_PULSE update at edge n+2+FILT_LEN (n+5 for the default).
- All outputs are registered.
- Strobes last exactly one CLK cycle.
- CE gaps stretch filter latency only. The decoder and period counter always run at CLK.
- Pulses shorter than FILT_LEN consecutive CE samples are rejected completely.
- Reset asserted mid-operation returns the block to the unprimed state within that cycle. On release, counting resumes only after a fresh priming.

## Structure
- Shared package microstep_pkg holds:
  - the forward Gray sequence constants (QS_00, QS_01, QS_11, QS_10)
  - the default CNT_W and PER_W
- Sub-module enc_filter: synchroniser, FILT_LEN shift register, primed flag, filtered output, rise/fall strobes. It is instantiated three times (A, B, Z).
- Top level holds the decode logic, POS/IDX registers, period counter and ERR.

## Test plan
- Reset, then hold A=B=0 for 10 cycles, then drive the forward sequence 01,11,10,00, each held 8 cycles -> no count from priming; POS = 4; DIR = 1; four CNT_PULSE; three PERIOD_VLD, each with PERIOD = 8.
- From POS = 4, drive 4 reverse steps, then 1 more -> POS = 0, then 0xFFFF; DIR = 0.
- Glitch A for 2 cycles with FILT_LEN=3 and CE high -> no filtered change, POS unchanged, ERR = 0.
- Jump {A,B} 00→11 -> ERR = 1 and POS unchanged. Then pulse ERR_CLR together with a second 11→00 jump -> ERR stays 1. Pulse ERR_CLR alone -> ERR = 0.
- With POS = 0x0123, give a Z rising edge, then in a later cycle assert CLR together with a forward count -> IDX_POS = 0x0123 and IDX_VLD pulses; after CLR, POS = 0.
- Assert RST_N low in the middle of a step sequence, then release -> all outputs 0; the first accepted {A,B} does not count.

Source files
------------

// File: rtl/microstep_pkg.sv
// ----------------------------------------------------------------------------
// microstep_pkg
// Shared definitions for the microstep driver family.
//   QS_00..QS_10 : forward Gray sequence of the encoder {A,B} lines
//                  (00 -> 01 -> 11 -> 10 -> 00)
//   CNT_W_DEF    : default width of position / index registers
//   PER_W_DEF    : default width of the step-period counter
//   gray_next()  : successor of a quadrature state in forward order
// ----------------------------------------------------------------------------
package microstep_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  localparam int CNT_W_DEF = 16;
  localparam int PER_W_DEF = 20;

  function automatic logic [1:0] gray_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      QS_00:   n = QS_01;
      QS_01:   n = QS_11;
      QS_11:   n = QS_10;
      default: n = QS_00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/enc_filter.sv
// ----------------------------------------------------------------------------
// enc_filter
// Conditions one raw encoder line: 2-flop synchroniser followed by a
// FILT_LEN-sample agreement filter clocked by the sample enable.
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   ce_i     : sample enable (one filter sample per asserted cycle)
//   line_i   : raw asynchronous encoder line
//   level_o  : filtered level (valid once primed_o is high)
//   primed_o : a first level has been accepted since reset
//   chg_o    : one-cycle strobe when an already primed level changes;
//              rise = chg_o & level_o, fall = chg_o & ~level_o
// ----------------------------------------------------------------------------
module enc_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ce_i,
  input  logic line_i,
  output logic level_o,
  output logic primed_o,
  output logic chg_o
);

  // The first two samples after reset can only carry the synchroniser's
  // reset value, so acceptance waits until they have left the window.
  localparam int            FW       = $clog2(FILT_LEN + 3);
  localparam logic [FW-1:0] FILL_MAX = FW'(FILT_LEN + 2);

  logic                sync1_q, sync2_q;
  logic [FILT_LEN-2:0] hist_q, hist_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic                level_q, level_d;
  logic                primed_q, primed_d;
  logic                chg_q, chg_d;
  logic [FILT_LEN-1:0] window;
  logic                all1, all0;

  always_comb begin
    window   = {hist_q, sync2_q};
    all1     = &window;
    all0     = ~|window;
    hist_d   = hist_q;
    fill_d   = fill_q;
    level_d  = level_q;
    primed_d = primed_q;
    chg_d    = 1'b0;
    if (ce_i) begin
      hist_d = window[FILT_LEN-2:0];
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FW'(1);
      end
      if ((fill_q == FILL_MAX) && (all1 || all0)) begin
        if (!primed_q) begin
          // Priming loads the level silently: no change strobe.
          primed_d = 1'b1;
          level_d  = all1;
        end else if (level_q != all1) begin
          level_d = all1;
          chg_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      hist_q   <= '0;
      fill_q   <= '0;
      level_q  <= 1'b0;
      primed_q <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      sync1_q  <= line_i;
      sync2_q  <= sync1_q;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      level_q  <= level_d;
      primed_q <= primed_d;
      chg_q    <= chg_d;
    end
  end

  assign level_o  = level_q;
  assign primed_o = primed_q;
  assign chg_o    = chg_q;

endmodule

// File: rtl/quad_encoder_decoder.sv
// ----------------------------------------------------------------------------
// quad_encoder_decoder
// 4x quadrature decoder with index capture, step-period measurement and
// illegal-transition detection.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   ENC_A/ENC_B/ENC_Z   : raw encoder lines (asynchronous)
//   CE                  : filter sample enable
//   CLR                 : synchronous clear of POS and the period counter
//   ERR_CLR             : synchronous clear of ERR
//   POS, DIR, CNT_PULSE : signed position, last direction, count strobe
//   IDX_POS, IDX_VLD    : POS captured on Z rising edge, capture strobe
//   PERIOD, PERIOD_VLD  : CLK cycles between the last two counts, strobe
//   ERR                 : sticky illegal-transition flag
// ----------------------------------------------------------------------------
module quad_encoder_decoder
  import microstep_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PER_W    = PER_W_DEF,
  parameter int FILT_LEN = 3
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    ENC_A,
  input  logic                    ENC_B,
  input  logic                    ENC_Z,
  input  logic                    CE,
  input  logic                    CLR,
  input  logic                    ERR_CLR,
  output logic signed [CNT_W-1:0] POS,
  output logic                    DIR,
  output logic                    CNT_PULSE,
  output logic signed [CNT_W-1:0] IDX_POS,
  output logic                    IDX_VLD,
  output logic [PER_W-1:0]        PERIOD,
  output logic                    PERIOD_VLD,
  output logic                    ERR
);

  logic a_lvl, a_pr, a_chg;
  logic b_lvl, b_pr, b_chg;
  logic z_lvl, z_pr, z_chg;

  enc_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk_i(CLK), .rst_ni(RST_N), .ce_i(CE), .line_i(ENC_A),
    .level_o(a_lvl), .primed_o(a_pr), .chg_o(a_chg)
  );

  enc_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk_i(CLK), .rst_ni(RST_N), .ce_i(CE), .line_i(ENC_B),
    .level_o(b_lvl), .primed_o(b_pr), .chg_o(b_chg)
  );

  enc_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (
    .clk_i(CLK), .rst_ni(RST_N), .ce_i(CE), .line_i(ENC_Z),
    .level_o(z_lvl), .primed_o(z_pr), .chg_o(z_chg)
  );

  logic                    dec_primed_q, dec_primed_d;
  logic [1:0]              ab_q, ab_d;
  logic signed [CNT_W-1:0] pos_q, pos_d;
  logic                    dir_q, dir_d;
  logic                    cnt_pulse_q, cnt_pulse_d;
  logic signed [CNT_W-1:0] idx_pos_q, idx_pos_d;
  logic                    idx_vld_q, idx_vld_d;
  logic [PER_W-1:0]        per_cnt_q, per_cnt_d;
  logic [PER_W-1:0]        period_q, period_d;
  logic                    period_vld_q, period_vld_d;
  logic                    per_seen_q, per_seen_d;
  logic                    err_q, err_d;

  logic [1:0] cur_ab;
  logic       step_evt, illegal, cnt_fwd, cnt_rev, count, z_rise;

  always_comb begin
    cur_ab   = {a_lvl, b_lvl};
    // Held state is only meaningful once the decoder is primed; the filter
    // change strobes tell us which lines moved this cycle.
    step_evt = dec_primed_q && (a_chg || b_chg);
    illegal  = step_evt && a_chg && b_chg;
    cnt_fwd  = step_evt && !illegal && (cur_ab == gray_next(ab_q));
    cnt_rev  = step_evt && !illegal && (ab_q == gray_next(cur_ab));
    count    = cnt_fwd || cnt_rev;
    z_rise   = z_pr && z_chg && z_lvl;

    dec_primed_d = dec_primed_q;
    ab_d         = ab_q;
    if (!dec_primed_q) begin
      if (a_pr && b_pr) begin
        dec_primed_d = 1'b1;
        ab_d         = cur_ab;
      end
    end else begin
      ab_d = cur_ab;
    end

    pos_d       = pos_q;
    dir_d       = dir_q;
    cnt_pulse_d = count;
    if (cnt_fwd) begin
      pos_d = pos_q + CNT_W'(1);
      dir_d = 1'b1;
    end else if (cnt_rev) begin
      pos_d = pos_q - CNT_W'(1);
      dir_d = 1'b0;
    end
    if (CLR) begin
      pos_d = '0;
    end

    // Index capture sees the position after this cycle's count and clear.
    idx_pos_d = idx_pos_q;
    idx_vld_d = z_rise;
    if (z_rise) begin
      idx_pos_d = pos_d;
    end

    per_cnt_d    = (&per_cnt_q) ? per_cnt_q : per_cnt_q + PER_W'(1);
    period_d     = period_q;
    period_vld_d = 1'b0;
    per_seen_d   = per_seen_q;
    if (CLR) begin
      // A count coinciding with CLR starts a fresh measurement.
      per_cnt_d  = '0;
      per_seen_d = 1'b0;
    end else if (count) begin
      per_cnt_d  = PER_W'(1);
      per_seen_d = 1'b1;
      if (per_seen_q) begin
        period_d     = per_cnt_q;
        period_vld_d = 1'b1;
      end
    end

    err_d = err_q;
    if (illegal) begin
      err_d = 1'b1;
    end else if (ERR_CLR) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dec_primed_q <= 1'b0;
      ab_q         <= QS_00;
      pos_q        <= '0;
      dir_q        <= 1'b0;
      cnt_pulse_q  <= 1'b0;
      idx_pos_q    <= '0;
      idx_vld_q    <= 1'b0;
      per_cnt_q    <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      per_seen_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      dec_primed_q <= dec_primed_d;
      ab_q         <= ab_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      cnt_pulse_q  <= cnt_pulse_d;
      idx_pos_q    <= idx_pos_d;
      idx_vld_q    <= idx_vld_d;
      per_cnt_q    <= per_cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      per_seen_q   <= per_seen_d;
      err_q        <= err_d;
    end
  end

  assign POS        = pos_q;
  assign DIR        = dir_q;
  assign CNT_PULSE  = cnt_pulse_q;
  assign IDX_POS    = idx_pos_q;
  assign IDX_VLD    = idx_vld_q;
  assign PERIOD     = period_q;
  assign PERIOD_VLD = period_vld_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_quad_encoder_decoder.sv
module tb_quad_encoder_decoder;

  localparam int F = 3;
  localparam int H = F + 3;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        A = 1'b0, B = 1'b0, Z = 1'b0;
  logic        CE = 1'b1, CLR = 1'b0, ERR_CLR = 1'b0;
  logic [15:0] POS, IDX_POS;
  logic        DIR, CNT_PULSE, IDX_VLD, PERIOD_VLD, ERR;
  logic [19:0] PERIOD;

  quad_encoder_decoder #(.CNT_W(16), .PER_W(20), .FILT_LEN(F)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENC_A(A), .ENC_B(B), .ENC_Z(Z), .CE(CE),
    .CLR(CLR), .ERR_CLR(ERR_CLR), .POS(POS), .DIR(DIR), .CNT_PULSE(CNT_PULSE),
    .IDX_POS(IDX_POS), .IDX_VLD(IDX_VLD), .PERIOD(PERIOD),
    .PERIOD_VLD(PERIOD_VLD), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A line's level is accepted once it has been seen unchanged on F
  // consecutive sampled edges; the decoder reacts to accepted levels.
  // The position is tracked as a phase index 0..3 along the Gray cycle.
  logic [2:0]  hist [H];
  int          ms = 0, kcyc = 0;
  bit          prim [3], lvl [3], oprim [3], olvl [3];
  bit          dprim = 0;
  int          held = 0, ph_now, diff, d;
  bit          illegal, agree, v;
  logic [15:0] m_pos = 0, m_idx = 0;
  logic [19:0] m_per = 0;
  bit          m_dir = 0, m_cp = 0, m_iv = 0, m_pv = 0, m_err = 0, seen = 0;
  int          last_k = 0;

  function automatic int phase(input bit a, input bit b);
    case ({a, b})
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ms = 0;
      for (int i = 0; i < H; i++) hist[i] = 3'b000;
      for (int j = 0; j < 3; j++) begin prim[j] = 0; lvl[j] = 0; end
      dprim = 0; held = 0; seen = 0; last_k = 0;
      m_pos = 0; m_idx = 0; m_per = 0;
      m_dir = 0; m_cp = 0; m_iv = 0; m_pv = 0; m_err = 0;
    end else begin
      kcyc++;
      for (int i = H - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {A, B, Z};
      if (ms < H + 1) ms++;
      for (int j = 0; j < 3; j++) begin
        oprim[j] = prim[j];
        olvl[j]  = lvl[j];
        if (ms >= F + 4) begin
          v = hist[3][2-j];
          agree = 1;
          for (int i = 3; i <= 2 + F; i++) if (hist[i][2-j] != v) agree = 0;
          if (agree) begin prim[j] = 1; lvl[j] = v; end
        end
      end
      m_cp = 0; m_pv = 0; m_iv = 0; illegal = 0; d = 0;
      if (!dprim) begin
        if (prim[0] && prim[1]) begin dprim = 1; held = phase(lvl[0], lvl[1]); end
      end else begin
        ph_now = phase(lvl[0], lvl[1]);
        diff = (ph_now - held + 4) % 4;
        if (diff == 1) d = 1;
        else if (diff == 3) d = -1;
        else if (diff == 2) illegal = 1;
        held = ph_now;
      end
      if (d != 0) begin
        m_pos = m_pos + 16'(d);
        m_dir = (d > 0);
        m_cp  = 1;
        if (seen && !CLR) begin m_per = 20'(kcyc - last_k); m_pv = 1; end
        seen = 1;
        last_k = kcyc;
      end
      if (CLR) begin m_pos = 0; seen = 0; end
      if (illegal) m_err = 1;
      else if (ERR_CLR) m_err = 0;
      if (oprim[2] && !olvl[2] && lvl[2]) begin m_idx = m_pos; m_iv = 1; end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("pos", 32'(POS), 32'(m_pos));
      chk("dir", 32'(DIR), 32'(m_dir));
      chk("cnt_pulse", 32'(CNT_PULSE), 32'(m_cp));
      chk("idx_pos", 32'(IDX_POS), 32'(m_idx));
      chk("idx_vld", 32'(IDX_VLD), 32'(m_iv));
      chk("period", 32'(PERIOD), 32'(m_per));
      chk("period_vld", 32'(PERIOD_VLD), 32'(m_pv));
      chk("err", 32'(ERR), 32'(m_err));
    end
  end

  // Strobe tallies for the directed literal checks.
  int          n_cnt = 0, n_pvld = 0, n_idx = 0;
  logic [19:0] last_per = 0;
  always @(negedge CLK) begin
    if (CNT_PULSE) n_cnt++;
    if (PERIOD_VLD) begin n_pvld++; last_per = PERIOD; end
    if (IDX_VLD) n_idx++;
  end

  // ---------------- directed stimulus ----------------
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int ph = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] ab, input int n);
    A = ab[1];
    B = ab[0];
    repeat (n) tick();
  endtask

  task automatic zero_tally();
    n_cnt = 0; n_pvld = 0; n_idx = 0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_pos", 32'(POS), 0);
    chk("rst_period", 32'(PERIOD), 0);
    chk("rst_err", 32'(ERR), 0);
    RST_N = 1'b1;
    chk_en = 1;

    // Priming then one forward revolution, 8 cycles per state.
    zero_tally();
    drive(2'b00, 10);
    chk("prime_no_count", 32'(n_cnt), 0);
    for (int i = 1; i <= 4; i++) drive(seq[i % 4], 8);
    repeat (8) tick();
    chk("fwd_pos", 32'(POS), 4);
    chk("fwd_dir", 32'(DIR), 1);
    chk("fwd_pulses", 32'(n_cnt), 4);
    chk("fwd_per_vld", 32'(n_pvld), 3);
    chk("fwd_period", 32'(last_per), 8);

    // Four reverse steps back to 0, then one more wraps below zero.
    drive(2'b10, 8); drive(2'b11, 8); drive(2'b01, 8); drive(2'b00, 8);
    repeat (8) tick();
    chk("rev_pos0", 32'(POS), 0);
    drive(2'b10, 8);
    repeat (8) tick();
    chk("rev_wrap", 32'(POS), 32'h0000_FFFF);
    chk("rev_dir", 32'(DIR), 0);

    // Two-cycle glitch on A is rejected.
    zero_tally();
    A = 1'b0; tick(); tick(); A = 1'b1;
    repeat (12) tick();
    chk("glitch_cnt", 32'(n_cnt), 0);
    chk("glitch_pos", 32'(POS), 32'h0000_FFFF);
    chk("glitch_err", 32'(ERR), 0);

    // Forward 10->00 wraps back to 0, then illegal jumps.
    drive(2'b00, 16);
    chk("wrap_up", 32'(POS), 0);
    drive(2'b11, 16);
    chk("illegal_err", 32'(ERR), 1);
    chk("illegal_pos", 32'(POS), 0);
    drive(2'b00, 5);
    ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
    chk("errclr_vs_illegal", 32'(ERR), 1);
    repeat (6) tick();
    ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
    chk("errclr_alone", 32'(ERR), 0);
    chk("illegal_pos2", 32'(POS), 0);

    // Walk to 0x0123, capture on Z, then CLR coinciding with a count.
    CLR = 1'b1; tick(); CLR = 1'b0;
    ph = 0;
    for (int i = 0; i < 291; i++) begin ph = (ph + 1) % 4; drive(seq[ph], 4); end
    repeat (8) tick();
    chk("walk_pos", 32'(POS), 32'h0123);
    zero_tally();
    Z = 1'b1; repeat (10) tick();
    chk("idx_pos", 32'(IDX_POS), 32'h0123);
    chk("idx_pulses", 32'(n_idx), 1);
    ph = 0;
    drive(seq[ph], 5);
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("clr_cnt_pos", 32'(POS), 0);
    chk("clr_cnt_dir", 32'(DIR), 1);
    chk("idx_held", 32'(IDX_POS), 32'h0123);

    // CLR coinciding with a Z rising edge captures zero.
    Z = 1'b0; repeat (10) tick();
    ph = 1; drive(seq[ph], 10);
    chk("pre_z_pos", 32'(POS), 1);
    Z = 1'b1; repeat (5) tick();
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("clr_z_idx", 32'(IDX_POS), 0);
    chk("clr_z_pos", 32'(POS), 0);

    // Reset in the middle of a step sequence.
    ph = 2; drive(seq[ph], 8);
    ph = 3; drive(seq[ph], 8);
    ph = 0; drive(seq[ph], 2);
    RST_N = 1'b0;
    #2;
    chk("mid_rst_pos", 32'(POS), 0);
    chk("mid_rst_idx", 32'(IDX_POS), 0);
    chk("mid_rst_period", 32'(PERIOD), 0);
    chk("mid_rst_dir", 32'(DIR), 0);
    repeat (3) tick();
    RST_N = 1'b1;
    zero_tally();
    repeat (12) tick();
    chk("reprime_cnt", 32'(n_cnt), 0);
    chk("reprime_pos", 32'(POS), 0);
    ph = 1; drive(seq[ph], 8);
    repeat (8) tick();
    chk("post_rst_pos", 32'(POS), 1);
    chk("post_rst_cnt", 32'(n_cnt), 1);
    chk("post_rst_pvld", 32'(n_pvld), 0);

    chk_en = 0;
    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
